// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory: default geometry and FSM state encoding.
package mem_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage with one byte-enabled write port and one registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH   = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [BE_WIDTH-1:0]   i_wstrb,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset so they map onto RAM macros;
  // contents are initialised only by the clear sequence.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (i_wstrb[b]) mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst.sv
// Burst-oriented memory slave: write/read bursts with address wrap, byte strobes and bulk clear.
module mem_burst
  import mem_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = $clog2(MAX_BURST),
  localparam int BE_WIDTH   = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [BE_WIDTH-1:0]   wstrb,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  input  logic                  clr,
  output logic                  busy,
  output logic                  err
);

  state_e                r_state, w_next_state;
  logic                  r_live;
  logic [ADDR_WIDTH-1:0] r_cur_addr, w_next_addr;
  logic [LEN_WIDTH-1:0]  r_beats;
  logic                  r_err, r_rvalid, r_rd_seen;
  logic                  w_clr_go, w_accept, w_bad_addr, w_last, w_wr_beat;
  logic                  w_we, w_re;
  logic [WIDTH-1:0]      w_wdata, w_arr_rdata;
  logic [BE_WIDTH-1:0]   w_wstrb;

  assign w_clr_go    = (r_state == ST_IDLE) && r_live && clr;
  assign w_accept    = (r_state == ST_IDLE) && r_live && valid && !clr;
  assign w_bad_addr  = 32'(addr) >= DEPTH;
  assign w_last      = (r_beats == '0);
  assign w_wr_beat   = (r_state == ST_WRITE) && valid;
  assign w_next_addr = (r_cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_cur_addr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_clr_go)                    w_next_state = ST_CLEAR;
        else if (w_accept && !w_bad_addr) w_next_state = wr_rd ? ST_WRITE : ST_READ;
      end
      ST_WRITE: if (w_wr_beat && w_last) w_next_state = ST_IDLE;
      ST_READ:  if (w_last)              w_next_state = ST_IDLE;
      ST_CLEAR: if (r_cur_addr == ADDR_WIDTH'(DEPTH - 1)) w_next_state = ST_IDLE;
      default:                           w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready   = r_live && ((r_state == ST_IDLE) || (r_state == ST_WRITE));
    busy    = (r_state != ST_IDLE);
    w_we    = w_wr_beat || (r_state == ST_CLEAR);
    w_re    = (r_state == ST_READ);
    w_wdata = (r_state == ST_CLEAR) ? '0 : wdata;
    w_wstrb = (r_state == ST_CLEAR) ? '1 : wstrb;
  end

  // Address/beat bookkeeping; r_live holds ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live     <= 1'b0;
      r_cur_addr <= '0;
      r_beats    <= '0;
      r_err      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_err     <= w_accept && w_bad_addr;
      r_rvalid  <= w_re;
      r_rd_seen <= r_rd_seen || w_re;
      unique case (r_state)
        ST_IDLE: begin
          if (w_clr_go) begin
            r_cur_addr <= '0;
          end else if (w_accept && !w_bad_addr) begin
            r_cur_addr <= addr;
            r_beats    <= len;
          end
        end
        ST_WRITE: begin
          if (w_wr_beat) begin
            r_cur_addr <= w_next_addr;
            r_beats    <= r_beats - 1'b1;
          end
        end
        ST_READ: begin
          r_cur_addr <= w_next_addr;
          r_beats    <= r_beats - 1'b1;
        end
        ST_CLEAR: r_cur_addr <= w_next_addr;
        default:  r_cur_addr <= '0;
      endcase
    end
  end

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_cur_addr),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .i_re    (w_re),
    .i_raddr (r_cur_addr),
    .o_rdata (w_arr_rdata)
  );

  // The read register is not reset, so rdata shows zero until the first read beat after reset.
  assign rdata  = r_rd_seen ? w_arr_rdata : '0;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule

// File: doc/mem_burst.md
MEM_BURST -- requirements
Module: mem_burst

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 64: number of words; need not be a power of two.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per burst.
REQ-004 Derived constants: ADDR_WIDTH = $clog2(DEPTH), LEN_WIDTH = $clog2(MAX_BURST), BE_WIDTH = WIDTH/8.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 valid  in  1  master request/beat qualifier.
REQ-008 ready  out  1  slave can accept the command or write beat this cycle.
REQ-009 wr_rd  in  1  1 = write burst, 0 = read burst; sampled at command accept.
REQ-010 addr  in  ADDR_WIDTH  burst start address; sampled at command accept.
REQ-011 len  in  LEN_WIDTH  beats minus one; sampled at command accept.
REQ-012 wdata  in  WIDTH  write data per beat.
REQ-013 wstrb  in  BE_WIDTH  per-byte write enable per beat.
REQ-014 rdata  out  WIDTH  read data.
REQ-015 rvalid  out  1  rdata qualifier, one pulse per read beat.
REQ-016 clr  in  1  request to zero the whole array; sampled in IDLE only.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-019 FSM states: IDLE, WRITE, READ, CLEAR.
REQ-020 IDLE: ready = 1; when clr = 1 the FSM enters CLEAR and clr takes priority over valid in the same cycle.
REQ-021 A command is accepted on valid && ready in IDLE; it latches addr, len and wr_rd into a current-address register and a beat counter.
REQ-022 A command with addr >= DEPTH is rejected: err pulses the next cycle, the FSM stays in IDLE, memory is unchanged.
REQ-023 WRITE: ready = 1; each valid && ready cycle writes wdata bytes where wstrb[i] = 1 to mem[cur_addr], then increments cur_addr; the command cycle carries no data.
REQ-024 READ: ready = 0; one beat per cycle with no backpressure; rdata = mem[cur_addr] with rvalid = 1 one cycle after each address is issued; the first rvalid occurs 2 cycles after command accept.
REQ-025 Address increment wraps from DEPTH-1 to 0.
REQ-026 The burst ends after len+1 beats and the FSM returns to IDLE; in READ, rvalid for the last beat coincides with IDLE.
REQ-027 CLEAR: ready = 0; writes 0 to one word per cycle from 0 to DEPTH-1 (DEPTH cycles), then returns to IDLE.
REQ-028 When not driven by a read beat, rvalid = 0 and rdata holds its last value.
REQ-029 In READ and CLEAR, valid, clr and wdata are ignored.

Reset
REQ-030 Reset asserted (rst = 0) forces, asynchronously: FSM = IDLE, ready = 0 while asserted, busy = 0, rvalid = 0, err = 0, rdata = 0, cur_addr = 0, beat counter = 0.
REQ-031 Array contents are not reset; clr is the only way to initialise them.
REQ-032 Reset mid-burst or mid-clear aborts the operation; words already written stay written.
REQ-033 ready = 1 from the first rising edge after rst deasserts.

Structure
REQ-034 A shared package mem_pkg SHALL hold the FSM state enum and the default WIDTH, DEPTH and MAX_BURST constants.
REQ-035 The storage array SHALL be a sub-module mem_array: one write port with byte enables, one registered read port, and no reset.
REQ-036 The array SHALL be reachable hierarchically as <inst>.u_array.mem so benches can preload and dump it by backdoor.

Verification
REQ-037 Write burst addr = 5, len = 3, data 0xA001..0xA004, wstrb = 2'b11; backdoor check: mem[5..8] = A001..A004.
REQ-038 Backdoor-load mem[62] = 0x1111, mem[63] = 0x2222, mem[0] = 0x3333, mem[1] = 0x4444; read addr = 62, len = 3 -> rdata 1111, 2222, 3333, 4444 on consecutive rvalid, first rvalid 2 cycles after accept (wrap).
REQ-039 mem[10] = 0xFFFF; write 0x1234 with wstrb = 2'b01 -> mem[10] = 0xFF34.
REQ-040 With DEPTH = 48, command addr = 50 -> err pulses once, ready stays 1, memory unchanged.
REQ-041 Backdoor fill all words with 0xBEEF, pulse clr -> busy high for 64 cycles, every word reads 0 afterwards; valid asserted during CLEAR is ignored.
REQ-042 Assert rst after 2 of 4 write beats -> outputs take reset values, only the first 2 words are written, next command works normally.
